// File: rtl/spin_sequencer_if.sv
// Command and result handshake bundle between the spinner command source and
// the sequencer.
interface spin_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       cmd_amount;
  logic [CNTW-1:0]  cmd_count;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_amount, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amount, cmd_count, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/spin_sequencer.sv
// Command stage for the 4-bit spinner: loads a word, recirculates it through
// the spinner count+1 times, captures the result and checks it against a model.
module spin_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 2
) (
  input  logic             clock,
  input  logic             reset,
  spin_sequencer_if.slave  bus,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] sp_din,
  output logic             sp_spin,
  output logic [1:0]       sp_amount,
  input  logic [WIDTH-1:0] sp_dout
);

  localparam int unsigned PASSW = CNTW + 1;
  localparam int unsigned CYCW  = PASSW + 1;
  localparam int unsigned PRODW = PASSW + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    LAST = 3'd3,
    CAPT = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d_q;
  logic [1:0]       a_q;
  logic [PASSW-1:0] c_q;
  logic [CYCW-1:0]  cnt;
  logic [1:0]       total_rot;
  logic [WIDTH-1:0] model;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic [1:0] amt);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = x[(i + 32'(amt)) % WIDTH];
    end
    return r;
  endfunction

  // Expected result: the word rotated by A per pass, C passes, modulo 4.
  assign total_rot = 2'(PRODW'(a_q) * PRODW'(c_q));
  assign model     = rotr(d_q, total_rot);

  assign bus.cmd_ready = (state == IDLE) && !bus.res_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      d_q           <= '0;
      a_q           <= '0;
      c_q           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      sp_din        <= '0;
      sp_spin       <= 1'b0;
      sp_amount     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            d_q       <= bus.cmd_data;
            a_q       <= bus.cmd_amount;
            c_q       <= PASSW'(bus.cmd_count) + PASSW'(1);
            sp_din    <= bus.cmd_data;
            sp_amount <= bus.cmd_amount;
            sp_spin   <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // Single pass needs no recirculation cycles.
          if (c_q == PASSW'(1)) begin
            sp_spin <= 1'b0;
            state   <= LAST;
          end else begin
            cnt     <= (CYCW'(c_q) << 1) - CYCW'(2);
            sp_spin <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt == CYCW'(1)) begin
            sp_spin <= 1'b0;
            state   <= LAST;
          end else begin
            cnt <= cnt - CYCW'(1);
          end
        end
        LAST: begin
          state <= CAPT;
        end
        CAPT: begin
          bus.res_data  <= sp_dout;
          bus.res_valid <= 1'b1;
          err           <= err | (sp_dout != model);
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          sp_spin <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
